// File: rtl/register_transfer_sequencer_if.sv
// Requester/register-file side of the transfer sequencer: requests, selects,
// grant/done handshake and the 12-bit register control bus.
interface register_transfer_sequencer_if #(
   parameter int SEL_W = 3
);
   logic [1:0]       req_in;
   logic [SEL_W-1:0] src0_in;
   logic [SEL_W-1:0] dst0_in;
   logic [SEL_W-1:0] src1_in;
   logic [SEL_W-1:0] dst1_in;
   logic [1:0]       grant_out;
   logic [1:0]       done_out;
   logic             bus_busy_out;
   logic [11:0]      Register_Control_Bus;

   modport master (
      output req_in, src0_in, dst0_in, src1_in, dst1_in,
      input  grant_out, done_out, bus_busy_out, Register_Control_Bus
   );

   modport slave (
      input  req_in, src0_in, dst0_in, src1_in, dst1_in,
      output grant_out, done_out, bus_busy_out, Register_Control_Bus
   );
endinterface

// File: rtl/register_transfer_sequencer.sv
// Round-robin register-to-register move sequencer. Every output is a flop so
// the register file sees glitch-free output-enable edges and load strobes.
module register_transfer_sequencer #(
   parameter int DRIVE_CYCLES = 1,
   parameter int SEL_W        = 3
) (
   input  logic                          clock_in,
   input  logic                          reset_in,
   register_transfer_sequencer_if.slave  rts
);
   typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [SEL_W-1:0] src_q, src_d;
   logic [SEL_W-1:0] dst_q, dst_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       done_q, done_d;
   logic             busy_q, busy_d;
   logic [11:0]      rcb_q, rcb_d;
   logic [1:0]       elig;
   logic             win;

   function automatic logic [11:0] oe_bits(input logic [SEL_W-1:0] s);
      logic [11:0] v;
      v = '0;
      for (int i = 0; i < 6; i++)
         if (s == SEL_W'(i)) v[6+i] = 1'b1;
      return v;
   endfunction

   function automatic logic [11:0] ld_bits(input logic [SEL_W-1:0] d);
      logic [11:0] v;
      v = '0;
      for (int i = 0; i < 6; i++)
         if (d == SEL_W'(i)) v[i] = 1'b1;
      return v;
   endfunction

   // Tie goes to whoever was not served last.
   function automatic logic pick(input logic [1:0] e, input logic last);
      return (e == 2'b11) ? ~last : e[1];
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      src_d   = src_q;
      dst_d   = dst_q;
      grant_d = grant_q;
      done_d  = 2'b00;
      busy_d  = busy_q;
      rcb_d   = rcb_q;
      elig    = 2'b00;
      win     = 1'b0;
      case (state_q)
         IDLE: begin
            // A requester still holding req while its done is visible is not a new request.
            elig = rts.req_in & ~done_q;
         end
         DRIVE: begin
            if (cnt_q == 4'd0) begin
               state_d = LOAD;
               rcb_d   = oe_bits(src_q) | ld_bits(dst_q);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         LOAD: begin
            state_d = RELEASE;
            rcb_d   = '0;
            busy_d  = 1'b0;
         end
         RELEASE: begin
            done_d  = owner_q ? 2'b10 : 2'b01;
            last_d  = owner_q;
            elig    = rts.req_in & (owner_q ? 2'b01 : 2'b10);
            state_d = IDLE;
            grant_d = 2'b00;
         end
         default: state_d = IDLE;
      endcase
      if (elig != 2'b00) begin
         win     = pick(elig, last_d);
         owner_d = win;
         src_d   = win ? rts.src1_in : rts.src0_in;
         dst_d   = win ? rts.dst1_in : rts.dst0_in;
         grant_d = win ? 2'b10 : 2'b01;
         cnt_d   = 4'(DRIVE_CYCLES - 1);
         busy_d  = 1'b1;
         rcb_d   = oe_bits(src_d);
         state_d = DRIVE;
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         rcb_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         rcb_q   <= rcb_d;
      end
   end

   // Selects are only consumed while a grant is active, so they need no reset.
   always_ff @(posedge clock_in) begin
      src_q <= src_d;
      dst_q <= dst_d;
   end

   assign rts.grant_out            = grant_q;
   assign rts.done_out             = done_q;
   assign rts.bus_busy_out         = busy_q;
   assign rts.Register_Control_Bus = rcb_q;
endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Bench for register_transfer_sequencer: two instances (DRIVE_CYCLES 1 and 4)
// compared every cycle against a transfer-phase reference model.
module tb_register_transfer_sequencer;
   localparam int DC0 = 1;
   localparam int DC1 = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   register_transfer_sequencer_if #(.SEL_W(3)) if0 ();
   register_transfer_sequencer_if #(.SEL_W(3)) if1 ();

   register_transfer_sequencer #(.DRIVE_CYCLES(DC0), .SEL_W(3)) dut0 (
      .clock_in(clk), .reset_in(rst), .rts(if0.slave));
   register_transfer_sequencer #(.DRIVE_CYCLES(DC1), .SEL_W(3)) dut1 (
      .clock_in(clk), .reset_in(rst), .rts(if1.slave));

   logic [1:0] s_req [2];
   logic [2:0] s_src [2][2];
   logic [2:0] s_dst [2][2];
   assign if0.req_in  = s_req[0];
   assign if0.src0_in = s_src[0][0];
   assign if0.dst0_in = s_dst[0][0];
   assign if0.src1_in = s_src[0][1];
   assign if0.dst1_in = s_dst[0][1];
   assign if1.req_in  = s_req[1];
   assign if1.src0_in = s_src[1][0];
   assign if1.dst0_in = s_dst[1][0];
   assign if1.src1_in = s_src[1][1];
   assign if1.dst1_in = s_dst[1][1];

   // Register file behind instance 0: OE drives the bus, load latches on negedge.
   logic [15:0] rf [6];
   logic [15:0] bus_v;
   logic        ext_en;
   logic [15:0] ext_val;
   always_comb begin
      bus_v = ext_en ? ext_val : 16'h0000;
      for (int j = 0; j < 6; j++)
         if (if0.Register_Control_Bus[6+j]) bus_v = rf[j];
   end
   always @(negedge clk) begin
      for (int j = 0; j < 6; j++) begin
         if (rst) rf[j] <= 16'h1000 + 16'(j) * 16'h0111;
         else if (if0.Register_Control_Bus[j]) rf[j] <= bus_v;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a transfer is a phase count k from its first drive cycle.
   bit         m_act  [2];
   int         m_k    [2];
   bit         m_own  [2];
   bit         m_last [2];
   logic [2:0] m_src  [2];
   logic [2:0] m_dst  [2];
   logic [1:0] m_done [2];
   bit         auto_drop;

   function automatic int dcv(input int u);
      return (u == 0) ? DC0 : DC1;
   endfunction

   function automatic logic [11:0] oe_of(input logic [2:0] s);
      return (s < 3'd6) ? (12'h040 << s) : 12'h000;
   endfunction

   function automatic logic [11:0] ld_of(input logic [2:0] d);
      return (d < 3'd6) ? (12'h001 << d) : 12'h000;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_act[u] = 0; m_k[u] = 0; m_own[u] = 0; m_last[u] = 1; m_done[u] = 2'b00;
      end
   endtask

   task automatic model_edge(input int u);
      logic [1:0] eff;
      logic [1:0] prevd;
      bit         w;
      prevd     = m_done[u];
      m_done[u] = 2'b00;
      eff       = 2'b00;
      if (m_act[u] && m_k[u] == dcv(u) + 1) begin
         m_done[u][m_own[u]] = 1'b1;
         m_last[u] = m_own[u];
         eff = s_req[u];
         eff[m_own[u]] = 1'b0;
         m_act[u] = 0;
      end else if (m_act[u]) begin
         m_k[u]++;
      end else begin
         eff = s_req[u] & ~prevd;
      end
      if (eff != 2'b00) begin
         w = (eff == 2'b11) ? !m_last[u] : eff[1];
         m_act[u] = 1; m_k[u] = 0; m_own[u] = w;
         m_src[u] = s_src[u][w];
         m_dst[u] = s_dst[u][w];
      end
   endtask

   task automatic check_outputs(input int u);
      logic [1:0]  g, d, eg;
      logic        b, eb;
      logic [11:0] c, ec;
      if (u == 0) begin
         g = if0.grant_out; d = if0.done_out; b = if0.bus_busy_out; c = if0.Register_Control_Bus;
      end else begin
         g = if1.grant_out; d = if1.done_out; b = if1.bus_busy_out; c = if1.Register_Control_Bus;
      end
      eg = m_act[u] ? (m_own[u] ? 2'b10 : 2'b01) : 2'b00;
      eb = m_act[u] && (m_k[u] <= dcv(u));
      if (!m_act[u])              ec = 12'h000;
      else if (m_k[u] < dcv(u))   ec = oe_of(m_src[u]);
      else if (m_k[u] == dcv(u))  ec = oe_of(m_src[u]) | ld_of(m_dst[u]);
      else                        ec = 12'h000;
      check_val(u == 0 ? "grant0" : "grant1", 32'(g), 32'(eg));
      check_val(u == 0 ? "done0" : "done1", 32'(d), 32'(m_done[u]));
      check_val(u == 0 ? "busy0" : "busy1", 32'(b), 32'(eb));
      check_val(u == 0 ? "rcb0" : "rcb1", 32'(c), 32'(ec));
      check_val(u == 0 ? "oe_onehot0" : "oe_onehot1", 32'($countones(c[11:6]) <= 1), 32'd1);
      check_val(u == 0 ? "ld_onehot0" : "ld_onehot1", 32'($countones(c[5:0]) <= 1), 32'd1);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else for (int u = 0; u < 2; u++) model_edge(u);
      #1;
      for (int u = 0; u < 2; u++) check_outputs(u);
      if (auto_drop)
         for (int u = 0; u < 2; u++)
            for (int i = 0; i < 2; i++)
               if (m_done[u][i]) s_req[u][i] = 1'b0;
   endtask

   logic [11:0] cap_rcb   [16];
   logic [1:0]  cap_done  [16];
   logic [1:0]  cap_grant [16];

   task automatic run_capture(input int u, input int n);
      for (int c = 1; c <= n; c++) begin
         cycle();
         cap_rcb[c]   = (u == 0) ? if0.Register_Control_Bus : if1.Register_Control_Bus;
         cap_done[c]  = (u == 0) ? if0.done_out : if1.done_out;
         cap_grant[c] = (u == 0) ? if0.grant_out : if1.grant_out;
      end
   endtask

   task automatic do_reset();
      for (int u = 0; u < 2; u++) s_req[u] = 2'b00;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int ndone;
      rst = 1'b1;
      ext_en = 1'b0;
      ext_val = 16'h0000;
      auto_drop = 1;
      for (int u = 0; u < 2; u++) begin
         s_req[u] = 2'b00;
         for (int i = 0; i < 2; i++) begin s_src[u][i] = 3'd7; s_dst[u][i] = 3'd7; end
      end
      model_reset();
      #1;
      check_val("rst_rcb", 32'(if0.Register_Control_Bus), 32'h0);
      check_val("rst_grant", 32'(if0.grant_out), 32'h0);
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // Single move A -> B.
      s_src[0][0] = 3'd0; s_dst[0][0] = 3'd1; s_req[0] = 2'b01;
      run_capture(0, 6);
      check_val("t1_grant", 32'(cap_grant[1]), 32'h1);
      check_val("t1_drive", 32'(cap_rcb[1]), 32'h040);
      check_val("t1_load", 32'(cap_rcb[2]), 32'h042);
      check_val("t1_release", 32'(cap_rcb[3]), 32'h000);
      check_val("t1_done", 32'(cap_done[4]), 32'h1);
      check_val("t1_regB", 32'(rf[1]), 32'h1000);

      // External driver into C.
      ext_en = 1'b1; ext_val = 16'h1234;
      s_src[0][0] = 3'd7; s_dst[0][0] = 3'd2; s_req[0] = 2'b01;
      run_capture(0, 6);
      check_val("t4_drive", 32'(cap_rcb[1]), 32'h000);
      check_val("t4_load", 32'(cap_rcb[2]), 32'h004);
      check_val("t4_regC", 32'(rf[2]), 32'h1234);
      ext_en = 1'b0;

      // Both requesters held: alternating grants, 3-cycle period.
      do_reset();
      auto_drop = 0;
      s_src[0][0] = 3'd1; s_dst[0][0] = 3'd2; s_src[0][1] = 3'd3; s_dst[0][1] = 3'd4;
      s_req[0] = 2'b11;
      run_capture(0, 12);
      check_val("t2_g1", 32'(cap_grant[1]), 32'h1);
      check_val("t2_g4", 32'(cap_grant[4]), 32'h2);
      check_val("t2_g7", 32'(cap_grant[7]), 32'h1);
      check_val("t2_g10", 32'(cap_grant[10]), 32'h2);
      s_req[0] = 2'b00;
      auto_drop = 1;
      repeat (8) cycle();

      // Long drive on instance 1: ST -> P.
      s_src[1][1] = 3'd5; s_dst[1][1] = 3'd3; s_req[1] = 2'b10;
      run_capture(1, 9);
      for (int c = 1; c <= 4; c++) check_val("t3_drive", 32'(cap_rcb[c]), 32'h800);
      check_val("t3_load", 32'(cap_rcb[5]), 32'h808);
      check_val("t3_release", 32'(cap_rcb[6]), 32'h000);
      check_val("t3_done", 32'(cap_done[7]), 32'h2);

      // Req dropped and selects changed after grant.
      s_src[0][0] = 3'd1; s_dst[0][0] = 3'd3; s_req[0] = 2'b01;
      cycle();
      check_val("t6_drive", 32'(if0.Register_Control_Bus), 32'h080);
      s_src[0][0] = 3'd4; s_dst[0][0] = 3'd5; s_req[0] = 2'b00;
      run_capture(0, 7);
      check_val("t6_load", 32'(cap_rcb[1]), 32'h088);
      ndone = 0;
      for (int c = 1; c <= 7; c++) if (cap_done[c] != 2'b00) ndone++;
      check_val("t6_done_count", 32'(ndone), 32'd1);
      check_val("t6_idle_grant", 32'(cap_grant[4]), 32'h0);

      // Asynchronous reset in the middle of LOAD.
      s_src[0][0] = 3'd0; s_dst[0][0] = 3'd1; s_src[0][1] = 3'd2; s_dst[0][1] = 3'd3;
      s_req[0] = 2'b11;
      cycle();
      cycle();
      check_val("t5_in_load", 32'(if0.bus_busy_out && if0.Register_Control_Bus[5:0] != 6'd0), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_val("t5_rcb", 32'(if0.Register_Control_Bus), 32'h0);
      check_val("t5_grant", 32'(if0.grant_out), 32'h0);
      check_val("t5_busy", 32'(if0.bus_busy_out), 32'h0);
      check_val("t5_done", 32'(if0.done_out), 32'h0);
      cycle();
      rst = 1'b0;
      cycle();
      check_val("t5_tie_grant", 32'(if0.grant_out), 32'h1);
      s_req[0] = 2'b00;
      repeat (12) cycle();

      // Random traffic on both instances.
      for (int n = 0; n < 800; n++) begin
         cycle();
         for (int u = 0; u < 2; u++)
            for (int i = 0; i < 2; i++) begin
               if (!s_req[u][i]) begin
                  if ($urandom_range(3) == 0) begin
                     s_req[u][i] = 1'b1;
                     s_src[u][i] = 3'($urandom_range(7));
                     s_dst[u][i] = 3'($urandom_range(7));
                  end
               end else if ($urandom_range(31) == 0) begin
                  s_req[u][i] = 1'b0;
               end else if ($urandom_range(7) == 0) begin
                  s_src[u][i] = 3'($urandom_range(7));
                  s_dst[u][i] = 3'($urandom_range(7));
               end
            end
      end
      for (int u = 0; u < 2; u++) s_req[u] = 2'b00;
      repeat (20) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/register_transfer_sequencer.md
Name: register_transfer_sequencer

Overview:
- Sequences register-to-register transfers on the shared 16-bit bus by driving the 12-bit Register_Control_Bus of the register file.
- Arbitrates between two requesters (fetch unit = 0, execute unit = 1) using round-robin, with a req/done handshake.
- Generates glitch-free output-enable and load strobes so each move meets register-file timing:
  - the output-enable rising edge captures the source value;
  - the load bit is sampled by the register file on negedge clock_in.

Parameters:
- DRIVE_CYCLES, 1, cycles the source output-enable is held before the load bit is asserted (bus settle time); legal range 1..15.
- SEL_W, 3, width of the register select codes.

Ports:
- clock_in  input  1  system clock; all state updates on posedge.
- reset_in  input  1  asynchronous, active-high reset.
- req_in  input  2  transfer request per requester; bit i held high until done_out[i].
- src0_in  input  3  requester 0 source select: 0=A 1=B 2=C 3=P 4=S 5=ST, 6/7=none (external driver owns bus).
- dst0_in  input  3  requester 0 destination select, same encoding; 6/7=none.
- src1_in  input  3  requester 1 source select.
- dst1_in  input  3  requester 1 destination select.
- grant_out  output  2  one-hot; high for the whole transfer owned by that requester.
- done_out  output  2  one-cycle pulse when the owner's transfer is complete.
- bus_busy_out  output  1  high in DRIVE and LOAD; other bus drivers stay off while it is high.
- Register_Control_Bus  output  12  [5:0] load A,B,C,P,S,ST; [11:6] output-enable A,B,C,P,S,ST.

Behaviour:
- Reset (async, immediate): state=IDLE; grant_out=0, done_out=0, bus_busy_out=0, Register_Control_Bus=0; last_grant=1, so requester 0 wins the first tie; drive counter=0.
- Every output comes directly from a flop, with no combinational decode after the register. The register file uses the OE bits as edge triggers, so glitches are forbidden.
- FSM states: IDLE, DRIVE, LOAD, RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not last_grant.
  - On grant: latch src/dst of the winner, set grant_out, load counter with DRIVE_CYCLES-1, go to DRIVE.
- DRIVE:
  - Register_Control_Bus[6+src]=1 if src<6, otherwise all OE bits are 0. bus_busy_out=1.
  - Counter decrements; when it reaches 0, go to LOAD.
- LOAD (exactly 1 cycle):
  - OE bit stays high.
  - Register_Control_Bus[dst]=1 if dst<6. The register file latches on the negedge within this cycle.
  - bus_busy_out=1.
- RELEASE (exactly 1 cycle):
  - All 12 control bits are 0 and bus_busy_out=0.
  - done_out[owner] pulses; last_grant is set to the owner.
  - Next state:
    - another request is pending (the owner's req may already be deasserted): arbitrate as in IDLE and go directly to DRIVE;
    - otherwise: go to IDLE and clear grant_out.
- The OE low time in RELEASE guarantees a fresh rising edge for the next transfer.
- Latency, req rise to done pulse: DRIVE_CYCLES+3 cycles from IDLE. Back-to-back throughput: one transfer per DRIVE_CYCLES+2 cycles.
- At most one OE bit and at most one load bit are high in any cycle.
- src==dst (both valid): executed normally; the register reloads its own value.
- src none, dst valid: no OE is driven; the external driver supplies the bus during LOAD.
- src and dst both none: full timing is still consumed, all control bits stay 0, done still pulses.
- Select inputs are sampled only at grant; changes during the transfer are ignored.
- A req deasserted mid-transfer does not abort; done still pulses.
- A req asserted in the same cycle as RELEASE is eligible for that arbitration.
- reset_in mid-transfer: outputs zero immediately, no done pulse; requesters must re-request.

Test Plan:
1. Reset, then req_in=01, src0=0 (A), dst0=1 (B), DRIVE_CYCLES=1.
   - grant_out=01 at cycle 1.
   - Control bus: 0x040 (DRIVE), 0x042 (LOAD), 0x000 (RELEASE).
   - done_out=01 at cycle 4.
   - Register B equals the prior value of A.
2. req_in=11 held, both requesters with different src/dst.
   - Grants alternate 01,10,01,10.
   - Each RELEASE goes straight to DRIVE; 3-cycle period.
   - No cycle has two OE bits set.
3. DRIVE_CYCLES=4, src1=5 (ST), dst1=3 (P).
   - 0x800 held 4 cycles, then 0x808 for 1 cycle, then 0x000.
   - done at cycle 7.
4. src0=7, dst0=2, bench drives 0x1234 on the bus during LOAD.
   - OE bits are 0 throughout.
   - Control bus is 0x004 in LOAD.
   - C=0x1234.
5. reset_in asserted mid-LOAD.
   - Control bus, grant_out and bus_busy_out are 0 immediately (asynchronously).
   - No done pulse.
   - After release, a tie grants requester 0.
6. Requester 0 drops req in DRIVE, and src0 is changed after grant.
   - Transfer completes using the originally latched selects.
   - done pulses once, then FSM returns to IDLE.
